mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single processor-to-memory port between the instruction cache and the data cache. Grants at most one request per cycle with data-cache priority plus a starvation guard, and records which requester owns each outstanding load tag. Routes returning memory data/tags only to the owning cache. Sits between `icache`/`dcache` and the memory model.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive data-cache grants with icache waiting before icache is forced through.
- `NUM_TAGS`, 16: tag space of the memory; tag 0 means "no tag".

Ports:
- `clock` in 1: single system clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `icache_command` in 2: BUS_NONE/BUS_LOAD (icache never stores).
- `icache_addr` in `XLEN`: fetch address.
- `dcache_command` in 2: BUS_NONE/BUS_LOAD/BUS_STORE.
- `dcache_addr` in `XLEN`; `dcache_data` in 64: store data.
- `squash_icache` in 1: discard all outstanding icache loads.
- `mem2proc_response` in 4, `mem2proc_data` in 64, `mem2proc_tag` in 4: memory port returns.
- `proc2mem_command` out 2, `proc2mem_addr` out `XLEN`, `proc2mem_data` out 64: to memory.
- `icache_response`/`dcache_response` out 4: acceptance tag to each cache, 0 if not accepted.
- `icache_mem_data`/`dcache_mem_data` out 64; `icache_mem_tag`/`dcache_mem_tag` out 4: routed returns.
- `outstanding_count` out 5: number of valid owner-table entries.
- `stray_tag` out 1: pulse when a nonzero `mem2proc_tag` has no valid owner.

## Operation
- Request valid: command != BUS_NONE.
- Grant (combinational): dcache if only dcache valid; icache if only icache valid; both valid → dcache unless `starve_cnt == STARVE_LIMIT`, then icache.
- `starve_cnt`: increments when both valid and dcache granted; cleared on any icache grant or when icache not requesting; saturates at STARVE_LIMIT.
- Granted requester's command/addr/data drive `proc2mem_*`; no grant → BUS_NONE, addr/data 0.
- `mem2proc_response` forwarded to granted requester only; non-granted response forced 0 (requester retries next cycle).
- Owner table: per tag 1..15, {valid, owner}. On accepted BUS_LOAD (response != 0), entry[response] ← {1, grantee}. Stores never create entries.
- On `mem2proc_tag != 0`: entry valid → data/tag to owner's `*_mem_*`, other side tag 0; entry cleared. Entry invalid → both tags 0, `stray_tag` = 1.
- `squash_icache`: clears all icache-owned entries at posedge; icache returns in the same cycle are already suppressed (tag 0 to icache) and do not raise `stray_tag`. Dcache entries unaffected. An icache load accepted in the same cycle as squash is also dropped.
- Same-cycle return and re-issue of tag t: clear then set; new entry wins.
- `*_mem_data` outputs carry `mem2proc_data` unconditionally; only tags qualify them.

## Timing
- Grant, `proc2mem_*`, `*_response` and return routing: combinational, zero latency.
- Owner table, `starve_cnt`, `outstanding_count`: registered, update at posedge.
- Reset: table cleared, `starve_cnt` 0, `outstanding_count` 0; while `reset` high, `proc2mem_command` = BUS_NONE, all responses/tags 0, `stray_tag` 0. Reset mid-transaction abandons in-flight loads; their later returns raise `stray_tag`.
- Response tag and return for a load never occur in the same cycle.

## Structure
- BUS_NONE/BUS_LOAD/BUS_STORE and `XLEN` from `sys_defs.svh`; add `MEM_TAG_BITS` = 4 and `MEM_OWNER_ICACHE`/`MEM_OWNER_DCACHE` constants there.
- One sub-module: `mem_tag_owner_table` (set/clear/squash ports, lookup, count).

## Test plan
- Icache alone LOAD addr 0x8, response 2 → `icache_response`=2, `dcache_response`=0; later tag 2, data 88 → `icache_mem_tag`=2, data 88, `dcache_mem_tag`=0, count 1→0.
- Both LOAD every cycle, STARVE_LIMIT 4, responses 1,2,3,… → grants D,D,D,D,I,D,D,D,D,I; starve_cnt returns 0 after icache grant.
- Dcache STORE, response 5 → `proc2mem_data` = `dcache_data`, no table entry; tag 5 later → `stray_tag`=1, both tags 0.
- Icache loads tags 3,4 outstanding, dcache tag 6; `squash_icache` pulse → count 1; returns 3,4 → icache tag 0, no stray; return 6 → dcache tag 6.
- Tag 7 returns (icache) while dcache accepted as new tag 7 same cycle → icache gets tag 7; next return 7 goes to dcache.
- Reset asserted with 3 entries outstanding → outputs zeroed during reset, count 0 after; stale return tag → `stray_tag`=1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: bus commands, widths, owner encoding and owner-table entry type shared by the arbiter files
package mem_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int MEM_TAG_BITS = 4;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  typedef logic [MEM_TAG_BITS-1:0] mem_tag_t;
  typedef enum logic {
    MEM_OWNER_ICACHE = 1'b0,
    MEM_OWNER_DCACHE = 1'b1
  } mem_owner_e;
  // squashed marks an icache load that was discarded but whose return is still due;
  // that return is swallowed silently instead of being reported as stray
  typedef struct packed {
    logic valid;
    logic squashed;
    mem_owner_e owner;
  } tag_entry_t;
endpackage

// File: rtl/mem_tag_owner_table.sv
// mem_tag_owner_table: per-tag record of which cache owns each outstanding memory load
//   clock/reset      : system clock, synchronous active-high reset
//   i_set*           : record an accepted load (tag, owner, dropped-by-squash flag)
//   i_clr_tag        : tag returning from memory this cycle (0 = none)
//   i_squash         : discard every outstanding icache-owned entry
//   i_lookup_tag     : tag looked up combinationally into o_lookup
//   o_count          : number of valid entries
module mem_tag_owner_table
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_set,
  input  mem_tag_t                  i_set_tag,
  input  mem_owner_e                i_set_owner,
  input  logic                      i_set_squashed,
  input  mem_tag_t                  i_clr_tag,
  input  logic                      i_squash,
  input  mem_tag_t                  i_lookup_tag,
  output tag_entry_t                o_lookup,
  output logic [$clog2(NUM_TAGS):0] o_count
);
  localparam int CW = $clog2(NUM_TAGS) + 1;
  tag_entry_t r_tab [NUM_TAGS];
  // set beats clear so a tag returned and re-issued in one cycle keeps the new owner;
  // clear beats squash so a returning squashed tag does not linger as a ghost
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (reset || i == 0) r_tab[i] <= '0;
      else if (i_set && i_set_tag == mem_tag_t'(i))
        r_tab[i] <= '{valid: !i_set_squashed, squashed: i_set_squashed, owner: i_set_owner};
      else if (i_clr_tag == mem_tag_t'(i)) r_tab[i] <= '0;
      else if (i_squash && r_tab[i].valid && r_tab[i].owner == MEM_OWNER_ICACHE)
        r_tab[i] <= '{valid: 1'b0, squashed: 1'b1, owner: MEM_OWNER_ICACHE};
    end
  end
  assign o_lookup = r_tab[i_lookup_tag];
  always_comb begin
    o_count = '0;
    for (int i = 0; i < NUM_TAGS; i++) o_count = o_count + CW'(r_tab[i].valid);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the memory port between icache and dcache and routes load returns to their owner
//   clock/reset                      : system clock, synchronous active-high reset
//   icache_*/dcache_*                : cache requests (icache loads only, dcache loads/stores)
//   squash_icache                    : drop every outstanding icache load
//   mem2proc_*                       : memory acceptance tag and returning data/tag
//   proc2mem_*                       : granted request toward memory
//   icache_response/dcache_response  : acceptance tag for the granted cache, 0 otherwise
//   icache_mem_*/dcache_mem_*        : returned data (unqualified) and tag (owner only)
//   outstanding_count                : valid owner-table entries
//   stray_tag                        : return tag with no owner on record
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              icache_command,
  input  logic [XLEN-1:0]         icache_addr,
  input  logic [1:0]              dcache_command,
  input  logic [XLEN-1:0]         dcache_addr,
  input  logic [63:0]             dcache_data,
  input  logic                    squash_icache,
  input  logic [MEM_TAG_BITS-1:0] mem2proc_response,
  input  logic [63:0]             mem2proc_data,
  input  logic [MEM_TAG_BITS-1:0] mem2proc_tag,
  output logic [1:0]              proc2mem_command,
  output logic [XLEN-1:0]         proc2mem_addr,
  output logic [63:0]             proc2mem_data,
  output logic [MEM_TAG_BITS-1:0] icache_response,
  output logic [MEM_TAG_BITS-1:0] dcache_response,
  output logic [63:0]             icache_mem_data,
  output logic [63:0]             dcache_mem_data,
  output logic [MEM_TAG_BITS-1:0] icache_mem_tag,
  output logic [MEM_TAG_BITS-1:0] dcache_mem_tag,
  output logic [4:0]              outstanding_count,
  output logic                    stray_tag
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  logic [SW-1:0] r_starve;
  logic w_ireq, w_dreq, w_gnt_i, w_gnt_d, w_set, w_ret;
  tag_entry_t w_entry;
  assign w_ireq = icache_command != BUS_NONE;
  assign w_dreq = dcache_command != BUS_NONE;
  // dcache wins ties until icache has watched STARVE_LIMIT dcache grants in a row
  assign w_gnt_i = !reset && w_ireq && (!w_dreq || r_starve == LIM);
  assign w_gnt_d = !reset && w_dreq && !w_gnt_i;
  assign proc2mem_command = w_gnt_d ? dcache_command : w_gnt_i ? icache_command : BUS_NONE;
  assign proc2mem_addr = w_gnt_d ? dcache_addr : w_gnt_i ? icache_addr : '0;
  assign proc2mem_data = w_gnt_d ? dcache_data : '0;
  assign icache_response = w_gnt_i ? mem2proc_response : '0;
  assign dcache_response = w_gnt_d ? mem2proc_response : '0;
  assign w_set = (w_gnt_i || w_gnt_d) && proc2mem_command == BUS_LOAD && mem2proc_response != '0;
  assign w_ret = !reset && mem2proc_tag != '0;
  assign icache_mem_data = mem2proc_data;
  assign dcache_mem_data = mem2proc_data;
  assign icache_mem_tag = (w_ret && w_entry.valid && w_entry.owner == MEM_OWNER_ICACHE && !squash_icache) ? mem2proc_tag : '0;
  assign dcache_mem_tag = (w_ret && w_entry.valid && w_entry.owner == MEM_OWNER_DCACHE) ? mem2proc_tag : '0;
  assign stray_tag = w_ret && !w_entry.valid && !w_entry.squashed;
  always_ff @(posedge clock) begin
    if (reset || w_gnt_i || !w_ireq) r_starve <= '0;
    else if (w_gnt_d && r_starve != LIM) r_starve <= r_starve + 1'b1;
  end
  mem_tag_owner_table #(.NUM_TAGS(NUM_TAGS)) u_table (
    .clock          (clock),
    .reset          (reset),
    .i_set          (w_set),
    .i_set_tag      (mem2proc_response),
    .i_set_owner    (w_gnt_i ? MEM_OWNER_ICACHE : MEM_OWNER_DCACHE),
    .i_set_squashed (w_gnt_i && squash_icache),
    .i_clr_tag      (w_ret ? mem2proc_tag : '0),
    .i_squash       (squash_icache),
    .i_lookup_tag   (mem2proc_tag),
    .o_lookup       (w_entry),
    .o_count        (outstanding_count)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven and randomized checks of mem_arbiter against a reference model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  localparam int LIM = 4;
  logic clock = 1'b0;
  logic reset;
  logic [1:0] icache_command, dcache_command, proc2mem_command;
  logic [XLEN-1:0] icache_addr, dcache_addr, proc2mem_addr;
  logic [63:0] dcache_data, mem2proc_data, proc2mem_data, icache_mem_data, dcache_mem_data;
  logic squash_icache, stray_tag;
  logic [3:0] mem2proc_response, mem2proc_tag, icache_response, dcache_response, icache_mem_tag, dcache_mem_tag;
  logic [4:0] outstanding_count;
  int n_chk = 0, n_fail = 0;
  bit mv[16], md[16], mg[16];
  int ms;
  typedef struct {
    logic [3:0] resp;
    logic [31:0] ia, da;
    logic [3:0] exp_ir, exp_dr;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vecs[10];

  mem_arbiter #(.STARVE_LIMIT(LIM), .NUM_TAGS(16)) dut (
    .clock(clock), .reset(reset),
    .icache_command(icache_command), .icache_addr(icache_addr),
    .dcache_command(dcache_command), .dcache_addr(dcache_addr), .dcache_data(dcache_data),
    .squash_icache(squash_icache),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .icache_response(icache_response), .dcache_response(dcache_response),
    .icache_mem_data(icache_mem_data), .dcache_mem_data(dcache_mem_data),
    .icache_mem_tag(icache_mem_tag), .dcache_mem_tag(dcache_mem_tag),
    .outstanding_count(outstanding_count), .stray_tag(stray_tag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] ic, input logic [31:0] ia, input logic [1:0] dc, input logic [31:0] da,
                     input logic [63:0] dd, input logic sq, input logic [3:0] resp, input logic [3:0] tag,
                     input logic [63:0] mdat, input logic rst);
    @(negedge clock);
    icache_command = ic; icache_addr = ia; dcache_command = dc; dcache_addr = da; dcache_data = dd;
    squash_icache = sq; mem2proc_response = resp; mem2proc_tag = tag; mem2proc_data = mdat; reset = rst;
    #1;
  endtask

  task automatic idle();
    cyc(2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ret(input logic [3:0] tag, input logic [63:0] mdat);
    cyc(2'd0, 0, 2'd0, 0, 0, 0, 0, tag, mdat, 0);
  endtask

  // expected outputs follow directly from the arbitration/routing rules and the model's tag records
  task automatic model_check();
    logic gi, gd, rt;
    int t, cnt;
    gi = !reset && icache_command != BUS_NONE && (dcache_command == BUS_NONE || ms == LIM);
    gd = !reset && dcache_command != BUS_NONE && !gi;
    t = int'(mem2proc_tag);
    rt = !reset && t != 0;
    cnt = 0;
    for (int i = 0; i < 16; i++) cnt += int'(mv[i]);
    chk("r_cmd", 64'(proc2mem_command), gd ? 64'(dcache_command) : gi ? 64'(icache_command) : 64'(BUS_NONE));
    chk("r_addr", 64'(proc2mem_addr), gd ? 64'(dcache_addr) : gi ? 64'(icache_addr) : 64'd0);
    chk("r_data", proc2mem_data, gd ? dcache_data : 64'd0);
    chk("r_iresp", 64'(icache_response), gi ? 64'(mem2proc_response) : 64'd0);
    chk("r_dresp", 64'(dcache_response), gd ? 64'(mem2proc_response) : 64'd0);
    chk("r_itag", 64'(icache_mem_tag), (rt && mv[t] && !md[t] && !squash_icache) ? 64'(t) : 64'd0);
    chk("r_dtag", 64'(dcache_mem_tag), (rt && mv[t] && md[t]) ? 64'(t) : 64'd0);
    chk("r_stray", 64'(stray_tag), 64'(rt && !mv[t] && !mg[t]));
    chk("r_count", 64'(outstanding_count), 64'(cnt));
    chk("r_idata", icache_mem_data, mem2proc_data);
  endtask

  task automatic model_update();
    logic gi, gd, ireq;
    int t, r;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin mv[i] = 0; md[i] = 0; mg[i] = 0; end
      ms = 0;
      return;
    end
    ireq = icache_command != BUS_NONE;
    gi = ireq && (dcache_command == BUS_NONE || ms == LIM);
    gd = dcache_command != BUS_NONE && !gi;
    t = int'(mem2proc_tag);
    r = int'(mem2proc_response);
    if (squash_icache)
      for (int i = 1; i < 16; i++) if (mv[i] && !md[i]) begin mv[i] = 0; mg[i] = 1; end
    if (t != 0) begin mv[t] = 0; mg[t] = 0; end
    if (r != 0 && ((gi && icache_command == BUS_LOAD) || (gd && dcache_command == BUS_LOAD))) begin
      md[r] = gd;
      mv[r] = !(gi && squash_icache);
      mg[r] = gi && squash_icache;
    end
    if (gi || !ireq) ms = 0;
    else if (gd && ms < LIM) ms++;
  endtask

  initial begin
    logic [9:0] pat;
    logic [1:0] ic, dc;
    pat = 10'b10_0001_0000;
    for (int k = 0; k < 10; k++) begin
      vecs[k].resp = 4'(k + 1);
      vecs[k].ia = 32'h100 + 32'(k);
      vecs[k].da = 32'h200 + 32'(k);
      vecs[k].exp_ir = pat[k] ? 4'(k + 1) : 4'd0;
      vecs[k].exp_dr = pat[k] ? 4'd0 : 4'(k + 1);
      vecs[k].exp_addr = pat[k] ? vecs[k].ia : vecs[k].da;
    end
    reset = 1; icache_command = 0; icache_addr = 0; dcache_command = 0; dcache_addr = 0; dcache_data = 0;
    squash_icache = 0; mem2proc_response = 0; mem2proc_tag = 0; mem2proc_data = 0;

    cyc(BUS_LOAD, 32'h4, BUS_LOAD, 32'h8, 64'h5, 0, 4'd3, 4'd2, 0, 1);
    chk("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    chk("rst_iresp", 64'(icache_response), 0);
    chk("rst_dresp", 64'(dcache_response), 0);
    chk("rst_itag", 64'(icache_mem_tag), 0);
    chk("rst_dtag", 64'(dcache_mem_tag), 0);
    chk("rst_stray", 64'(stray_tag), 0);
    idle();
    chk("rst_count", 64'(outstanding_count), 0);

    cyc(BUS_LOAD, 32'h8, BUS_NONE, 0, 0, 0, 4'd2, 0, 0, 0);
    chk("a_iresp", 64'(icache_response), 2);
    chk("a_dresp", 64'(dcache_response), 0);
    chk("a_cmd", 64'(proc2mem_command), 64'(BUS_LOAD));
    chk("a_addr", 64'(proc2mem_addr), 64'h8);
    idle();
    chk("a_count1", 64'(outstanding_count), 1);
    ret(4'd2, 64'd88);
    chk("a_itag", 64'(icache_mem_tag), 2);
    chk("a_idata", icache_mem_data, 64'd88);
    chk("a_dtag", 64'(dcache_mem_tag), 0);
    chk("a_stray", 64'(stray_tag), 0);
    idle();
    chk("a_count0", 64'(outstanding_count), 0);

    for (int k = 0; k < 10; k++) begin
      cyc(BUS_LOAD, vecs[k].ia, BUS_LOAD, vecs[k].da, 64'h1234, 0, vecs[k].resp, 0, 0, 0);
      chk($sformatf("starve_iresp%0d", k), 64'(icache_response), 64'(vecs[k].exp_ir));
      chk($sformatf("starve_dresp%0d", k), 64'(dcache_response), 64'(vecs[k].exp_dr));
      chk($sformatf("starve_addr%0d", k), 64'(proc2mem_addr), 64'(vecs[k].exp_addr));
    end
    idle();
    chk("starve_count", 64'(outstanding_count), 10);
    cyc(2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1);

    cyc(BUS_NONE, 0, BUS_STORE, 32'h40, 64'hDEAD_BEEF, 0, 4'd5, 0, 0, 0);
    chk("st_cmd", 64'(proc2mem_command), 64'(BUS_STORE));
    chk("st_data", proc2mem_data, 64'hDEAD_BEEF);
    chk("st_dresp", 64'(dcache_response), 5);
    idle();
    chk("st_count", 64'(outstanding_count), 0);
    ret(4'd5, 64'h55);
    chk("st_stray", 64'(stray_tag), 1);
    chk("st_itag", 64'(icache_mem_tag), 0);
    chk("st_dtag", 64'(dcache_mem_tag), 0);

    cyc(BUS_LOAD, 32'h10, BUS_NONE, 0, 0, 0, 4'd3, 0, 0, 0);
    cyc(BUS_LOAD, 32'h14, BUS_NONE, 0, 0, 0, 4'd4, 0, 0, 0);
    cyc(BUS_NONE, 0, BUS_LOAD, 32'h18, 0, 0, 4'd6, 0, 0, 0);
    idle();
    chk("sq_count3", 64'(outstanding_count), 3);
    cyc(2'd0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0);
    idle();
    chk("sq_count1", 64'(outstanding_count), 1);
    ret(4'd3, 64'h33);
    chk("sq_itag3", 64'(icache_mem_tag), 0);
    chk("sq_stray3", 64'(stray_tag), 0);
    ret(4'd4, 64'h44);
    chk("sq_itag4", 64'(icache_mem_tag), 0);
    chk("sq_stray4", 64'(stray_tag), 0);
    ret(4'd6, 64'h66);
    chk("sq_dtag6", 64'(dcache_mem_tag), 6);
    chk("sq_stray6", 64'(stray_tag), 0);

    cyc(BUS_LOAD, 32'h20, BUS_NONE, 0, 0, 0, 4'd7, 0, 0, 0);
    idle();
    cyc(BUS_NONE, 0, BUS_LOAD, 32'h24, 0, 0, 4'd7, 4'd7, 64'h77, 0);
    chk("re_itag", 64'(icache_mem_tag), 7);
    chk("re_dtag", 64'(dcache_mem_tag), 0);
    chk("re_dresp", 64'(dcache_response), 7);
    idle();
    chk("re_count", 64'(outstanding_count), 1);
    ret(4'd7, 64'h78);
    chk("re_dtag2", 64'(dcache_mem_tag), 7);
    chk("re_itag2", 64'(icache_mem_tag), 0);
    idle();
    chk("re_count0", 64'(outstanding_count), 0);

    cyc(BUS_NONE, 0, BUS_LOAD, 32'h30, 0, 0, 4'd1, 0, 0, 0);
    cyc(BUS_NONE, 0, BUS_LOAD, 32'h34, 0, 0, 4'd2, 0, 0, 0);
    cyc(BUS_LOAD, 32'h38, BUS_NONE, 0, 0, 0, 4'd3, 0, 0, 0);
    idle();
    chk("mr_count3", 64'(outstanding_count), 3);
    cyc(BUS_LOAD, 32'h3c, BUS_LOAD, 32'h40, 0, 0, 4'd4, 4'd1, 0, 1);
    chk("mr_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    chk("mr_iresp", 64'(icache_response), 0);
    chk("mr_dresp", 64'(dcache_response), 0);
    chk("mr_dtag", 64'(dcache_mem_tag), 0);
    chk("mr_stray", 64'(stray_tag), 0);
    idle();
    chk("mr_count0", 64'(outstanding_count), 0);
    ret(4'd2, 64'h22);
    chk("mr_stray2", 64'(stray_tag), 1);
    chk("mr_dtag2", 64'(dcache_mem_tag), 0);

    cyc(2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1);
    model_update();
    for (int n = 0; n < 400; n++) begin
      ic = ($urandom_range(0, 9) < 6) ? BUS_LOAD : BUS_NONE;
      dc = 2'($urandom_range(0, 2));
      cyc(ic, $urandom, dc, $urandom, {$urandom, $urandom}, $urandom_range(0, 19) == 0,
          $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'd0,
          $urandom_range(0, 2) != 0 ? 4'($urandom_range(1, 15)) : 4'd0,
          {$urandom, $urandom}, $urandom_range(0, 49) == 0);
      model_check();
      model_update();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
